// File: rtl/nx_fifo_rd_arb.sv
// nx_fifo_rd_arb: packet-aware round-robin read scheduler.
// Drains N_SRC show-ahead FIFOs into one registered valid/ready stream.
// A grant is held on one source from its first word to its EOP word, so
// packets are never interleaved on the output.
// Optional per-source popped-word counters: define NX_FIFO_RD_ARB_STATS_EN.
module nx_fifo_rd_arb #(
    parameter int N_SRC   = 4,
    parameter int WIDTH   = 132,
    parameter int EOP_BIT = 131,
    parameter int SRC_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [N_SRC-1:0]         src_mask,
    input  logic [N_SRC-1:0]         src_empty,
    input  logic [N_SRC*WIDTH-1:0]   src_rdata,
    output logic [N_SRC-1:0]         src_ren,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]         out_src,
    input  logic                     out_ready,
    output logic                     busy,
    input  logic                     stats_clr,
    output logic [N_SRC*CNT_W-1:0]   grant_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_r;
    logic [SRC_W-1:0]   rr_ptr_r;
    logic [SRC_W-1:0]   lock_src_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [SRC_W-1:0]   out_src_r;

    logic               can_pop_s;
    logic [N_SRC-1:0]   elig_s;
    logic               rr_found_s;
    logic [SRC_W-1:0]   rr_sel_s;
    logic               pop_s;
    logic [SRC_W-1:0]   sel_s;
    logic [WIDTH-1:0]   sel_word_s;
    logic               sel_eop_s;
    logic [SRC_W-1:0]   next_ptr_s;
    logic [N_SRC-1:0]   src_ren_s;

    // Index of the source after idx, wrapping at N_SRC.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
        if (idx == SRC_W'(N_SRC - 1)) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = idx + SRC_W'(1);
        end
    endfunction

    // The output register can take a new word when it is empty or draining.
    assign can_pop_s = !out_valid_r || out_ready;
    assign elig_s    = ~src_empty & ~src_mask & {N_SRC{enable}};

    // Round-robin search for the first eligible source starting at rr_ptr.
    always_comb begin
        int idx_v;
        idx_v      = 0;
        rr_found_s = 1'b0;
        rr_sel_s   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx_v = (int'(rr_ptr_r) + k) % N_SRC;
            if (!rr_found_s && elig_s[idx_v]) begin
                rr_found_s = 1'b1;
                rr_sel_s   = SRC_W'(idx_v);
            end else begin
                rr_sel_s   = rr_sel_s;
            end
        end
    end

    // Pop decision: new packet selection in IDLE, owner-only while LOCKED.
    always_comb begin
        pop_s = 1'b0;
        sel_s = rr_sel_s;
        case (state_r)
            ST_IDLE: begin
                sel_s = rr_sel_s;
                if (!rst && rr_found_s && can_pop_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                sel_s = lock_src_r;
                if (!rst && !src_empty[lock_src_r] && can_pop_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                sel_s = '0;
                pop_s = 1'b0;
            end
        endcase
    end

    // Head-word mux for the selected source and one-hot pop generation.
    always_comb begin
        sel_word_s = '0;
        src_ren_s  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel_s == SRC_W'(i)) begin
                sel_word_s   = src_rdata[i*WIDTH +: WIDTH];
                src_ren_s[i] = pop_s;
            end else begin
                src_ren_s[i] = 1'b0;
            end
        end
    end

    assign sel_eop_s  = sel_word_s[EOP_BIT];
    assign next_ptr_s = wrap_inc(sel_s);

    // Packet FSM: lock onto a source until its EOP word is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            lock_src_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s && sel_eop_s) begin
                        rr_ptr_r <= next_ptr_s;
                    end else if (pop_s) begin
                        state_r    <= ST_LOCKED;
                        lock_src_r <= sel_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (pop_s && sel_eop_s) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= next_ptr_s;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: load on pop, clear when accepted, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
        end else if (pop_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_word_s;
            out_src_r   <= sel_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign src_ren   = src_ren_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign busy      = (state_r == ST_LOCKED) || out_valid_r;

`ifdef NX_FIFO_RD_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_r [N_SRC];

    // Saturating per-source pop counters; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (src_ren_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Flatten the counter array onto the grant_cnt bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end
`else
    logic stats_unused_s;

    assign stats_unused_s = stats_clr;
    assign grant_cnt      = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_arb.sv
// Self-checking bench for nx_fifo_rd_arb: FIFO queue model, a table of
// first-grant vectors, directed multi-cycle sequences and a randomized run
// checked against a cycle-level scheduler model.
module tb_nx_fifo_rd_arb;

    localparam int N     = 4;
    localparam int W     = 132;
    localparam int EOP   = 131;
    localparam int SW    = 2;
    localparam int CW    = 4;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [N-1:0]     src_mask;
    logic [N-1:0]     src_empty;
    logic [N*W-1:0]   src_rdata;
    logic [N-1:0]     src_ren;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_src;
    logic             out_ready;
    logic             busy;
    logic             stats_clr;
    logic [N*CW-1:0]  grant_cnt;

    always #5 clk = ~clk;

    nx_fifo_rd_arb #(
        .N_SRC(N), .WIDTH(W), .EOP_BIT(EOP), .SRC_W(SW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .src_mask(src_mask),
        .src_empty(src_empty), .src_rdata(src_rdata), .src_ren(src_ren),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .busy(busy), .stats_clr(stats_clr),
        .grant_cnt(grant_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Source FIFO contents (environment)
    logic [W-1:0] fmem [N][DEPTH];
    int           fhead [N];
    int           fcnt  [N];

    // Reference scheduler state: owner -1 means no packet in flight
    int           m_owner;
    int           m_rr;
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_os;
    int           m_cnt [N];

    // Accepted-word log and per-cycle pop history
    logic [W-1:0] log_d [64];
    int           log_s [64];
    int           log_n;
    logic [N-1:0] hist [32];
    int           hist_n;

    typedef struct {
        logic [N-1:0] empty;
        logic [N-1:0] mask;
        logic         en;
        logic [N-1:0] exp_ren;
    } vec_t;
    vec_t vecs [9];

    function automatic logic [W-1:0] mk(input int unsigned v, input logic eop);
        logic [W-1:0] w;
        w        = '0;
        w[31:0]  = v;
        w[EOP]   = eop;
        return w;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic [W-1:0] w);
        if (fcnt[s] < DEPTH) begin
            fmem[s][(fhead[s] + fcnt[s]) % DEPTH] = w;
            fcnt[s]++;
        end
    endtask

    task automatic flush_fifos();
        for (int i = 0; i < N; i++) begin
            fcnt[i]  = 0;
            fhead[i] = 0;
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            src_empty[i]        = (fcnt[i] == 0);
            src_rdata[i*W +: W] = (fcnt[i] != 0) ? fmem[i][fhead[i]] : '0;
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_ov    = 1'b0;
        m_od    = '0;
        m_os    = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock: predict, compare, advance model, pop FIFOs on the DUT's ren.
    task automatic tick();
        int           pick;
        int           j;
        logic         can;
        logic [N-1:0] ren_now;
        logic [N-1:0] exp_ren;
        logic [W-1:0] word;
        int           exp_cnt;
        drive_src();
        #1;
        ren_now = src_ren;
        can     = !m_ov || out_ready;
        pick    = -1;
        if (!rst) begin
            if (m_owner < 0) begin
                if (can) begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_rr + k) % N;
                        if (pick < 0 && fcnt[j] > 0 && !src_mask[j] && enable) pick = j;
                    end
                end
            end else if (can && fcnt[m_owner] > 0) begin
                pick = m_owner;
            end
        end
        exp_ren = '0;
        if (pick >= 0) exp_ren[pick] = 1'b1;
        chk("src_ren", W'(ren_now), W'(exp_ren));
        chk("out_valid", W'(out_valid), W'(m_ov));
        chk("busy", W'(busy), W'((m_owner >= 0) || m_ov));
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_src", W'(out_src), W'(m_os));
        end
        for (int i = 0; i < N; i++) begin
`ifdef NX_FIFO_RD_ARB_STATS_EN
            exp_cnt = m_cnt[i];
`else
            exp_cnt = 0;
`endif
            chk("grant_cnt", W'(grant_cnt[i*CW +: CW]), W'(exp_cnt));
        end
        if (!rst && out_valid && out_ready && log_n < 64) begin
            log_d[log_n] = out_data;
            log_s[log_n] = int'(out_src);
            log_n++;
        end
        if (hist_n < 32) begin
            hist[hist_n] = ren_now;
            hist_n++;
        end
        if (rst) begin
            model_reset();
        end else begin
            if (pick >= 0) begin
                word = fmem[pick][fhead[pick]];
                m_ov = 1'b1;
                m_od = word;
                m_os = pick;
                if (word[EOP]) begin
                    m_owner = -1;
                    m_rr    = (pick + 1) % N;
                end else begin
                    m_owner = pick;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (stats_clr) m_cnt[i] = 0;
                else if (pick == i && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
            end
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (ren_now[i] && fcnt[i] > 0) begin
                fhead[i] = (fhead[i] + 1) % DEPTH;
                fcnt[i]--;
            end
        end
        @(negedge clk);
    endtask

    task automatic restart();
        rst = 1'b1;
        tick();
        flush_fifos();
        rst       = 1'b0;
        src_mask  = '0;
        enable    = 1'b1;
        out_ready = 1'b1;
        stats_clr = 1'b0;
        log_n     = 0;
        hist_n    = 0;
    endtask

    task automatic chk_log(input int idx, input logic [W-1:0] d, input int s);
        chk("log_data", log_d[idx], d);
        chk("log_src", W'(log_s[idx]), W'(s));
    endtask

    initial begin
        logic [N-1:0] e;
        int           s;
        rst = 1'b1; enable = 1'b0; src_mask = '0; out_ready = 1'b1;
        stats_clr = 1'b0; src_empty = '1; src_rdata = '0;
        log_n = 0; hist_n = 0;
        flush_fifos();
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        tick();
        chk("rst_out_data", out_data, '0);
        chk("rst_out_src", W'(out_src), W'(0));

        // All sources empty: nothing happens for 10 cycles
        rst = 1'b0; enable = 1'b1;
        repeat (10) tick();

        // First grant after reset (rr_ptr = 0)
        vecs[0] = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
        vecs[1] = '{4'b0000, 4'b0000, 1'b1, 4'b0001};
        vecs[2] = '{4'b0000, 4'b0001, 1'b1, 4'b0010};
        vecs[3] = '{4'b0011, 4'b0000, 1'b1, 4'b0100};
        vecs[4] = '{4'b0111, 4'b0000, 1'b1, 4'b1000};
        vecs[5] = '{4'b0000, 4'b1111, 1'b1, 4'b0000};
        vecs[6] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
        vecs[7] = '{4'b1110, 4'b0001, 1'b1, 4'b0000};
        vecs[8] = '{4'b0101, 4'b1000, 1'b1, 4'b0010};
        for (int v = 0; v < 9; v++) begin
            restart();
            for (int i = 0; i < N; i++) begin
                if (!vecs[v].empty[i]) push(i, mk(32'h10 + i, 1'b1));
            end
            src_mask = vecs[v].mask;
            enable   = vecs[v].en;
            drive_src();
            #1;
            chk("vec_ren", W'(src_ren), W'(vecs[v].exp_ren));
        end

        // Single-word packets from every source, served in order
        restart();
        for (int i = 0; i < N; i++) push(i, mk(32'hA0 + i, 1'b1));
        repeat (8) tick();
        for (int k = 0; k < 5; k++) begin
            e = '0;
            if (k < 4) e[k] = 1'b1;
            chk("rr_order_ren", W'(hist[k]), W'(e));
        end
        chk("rr_order_count", W'(log_n), W'(4));
        for (int k = 0; k < 4; k++) chk_log(k, mk(32'hA0 + k, 1'b1), k);

        // Locked source starves: no other source served during the bubble
        restart();
        push(1, mk(32'hB1, 1'b0));
        push(2, mk(32'hC1, 1'b1));
        repeat (3) tick();
        chk("bubble_ren1", W'(hist[1]), W'(0));
        chk("bubble_ren2", W'(hist[2]), W'(0));
        push(1, mk(32'hB2, 1'b0));
        push(1, mk(32'hB3, 1'b1));
        repeat (6) tick();
        chk("bubble_count", W'(log_n), W'(4));
        chk_log(0, mk(32'hB1, 1'b0), 1);
        chk_log(1, mk(32'hB2, 1'b0), 1);
        chk_log(2, mk(32'hB3, 1'b1), 1);
        chk_log(3, mk(32'hC1, 1'b1), 2);

        // Backpressure: hold, then resume without loss or duplication
        restart();
        for (int k = 0; k < 6; k++) push(0, mk(32'hD0 + k, 1'b1));
        repeat (2) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        for (int k = 2; k < 7; k++) chk("bp_no_pop", W'(hist[k]), W'(0));
        out_ready = 1'b1;
        repeat (10) tick();
        chk("bp_count", W'(log_n), W'(6));
        for (int k = 0; k < 6; k++) chk_log(k, mk(32'hD0 + k, 1'b1), 0);

        // Mask and disable while locked: packet completes, then skip/stop
        restart();
        push(0, mk(32'hE0, 1'b0));
        push(0, mk(32'hE1, 1'b0));
        push(0, mk(32'hE2, 1'b1));
        push(1, mk(32'hF0, 1'b1));
        push(2, mk(32'h60, 1'b1));
        tick();
        src_mask = 4'b0001;
        enable   = 1'b0;
        push(0, mk(32'hE3, 1'b1));
        repeat (5) tick();
        chk("mask_count_a", W'(log_n), W'(3));
        for (int k = 0; k < 3; k++) chk_log(k, mk(32'hE0 + k, (k == 2)), 0);
        enable = 1'b1;
        repeat (6) tick();
        chk("mask_count_b", W'(log_n), W'(5));
        chk_log(3, mk(32'hF0, 1'b1), 1);
        chk_log(4, mk(32'h60, 1'b1), 2);
        chk("mask_left", W'(fcnt[0]), W'(1));

        // Reset mid-packet
        restart();
        push(3, mk(32'h1, 1'b0));
        push(3, mk(32'h2, 1'b0));
        repeat (2) tick();
        chk("mid_busy_before", W'(busy), W'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flush_fifos();
        tick();
        chk("mid_busy_after", W'(busy), W'(0));

        // Counter saturation and clear-vs-increment (source 3, rr wrap)
        restart();
        for (int k = 0; k < 17; k++) push(3, mk(32'h300 + k, 1'b1));
        repeat (20) tick();
`ifdef NX_FIFO_RD_ARB_STATS_EN
        chk("cnt_sat", W'(grant_cnt[3*CW +: CW]), W'(15));
`else
        chk("cnt_off", W'(grant_cnt[3*CW +: CW]), W'(0));
`endif
        push(3, mk(32'h399, 1'b1));
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        tick();
        chk("cnt_clr", W'(grant_cnt[3*CW +: CW]), W'(0));

        // Randomized traffic against the model
        restart();
        for (int c = 0; c < 2000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) src_mask = 4'($urandom_range(0, 15));
            stats_clr = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, N - 1);
                if (fcnt[s] < DEPTH - 2) push(s, mk($urandom, ($urandom_range(0, 2) == 0)));
            end
            tick();
        end
        rst = 1'b0; src_mask = '0; enable = 1'b1; out_ready = 1'b1; stats_clr = 1'b0;
        repeat (200) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nx_fifo_rd_arb.md
Name: nx_fifo_rd_arb

Overview:
- Packet-aware round-robin read scheduler that drains N_SRC show-ahead nx_fifo instances into one registered valid/ready output stream.
- Each source FIFO presents `empty` and a combinational head word `rdata`. The block drives each FIFO's `ren`.
- Grant is held on one source from first word to end-of-packet word, so packets are never interleaved.
- Sits between the per-engine output FIFOs and the shared downstream bus.

Parameters:
- N_SRC, 4: number of source FIFOs (2..16).
- WIDTH, 132: data word width; matches the FIFO WIDTH.
- EOP_BIT, 131: bit index in the word marking the last word of a packet.
- SRC_W, 2: width of the source index; must be >= clog2(N_SRC).
- CNT_W, 16: width of each per-source word counter (optional feature only).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  allow new packets to start.
- src_mask  input  N_SRC  1 = source excluded from new-packet selection.
- src_empty  input  N_SRC  per-FIFO empty flag.
- src_rdata  input  N_SRC*WIDTH  per-FIFO head word; source i occupies bits [i*WIDTH +: WIDTH].
- src_ren  output  N_SRC  per-FIFO pop; one-hot or zero.
- out_valid  output  1  output word valid.
- out_data  output  WIDTH  output word.
- out_src  output  SRC_W  index of the source that supplied out_data.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- busy  output  1  packet in progress or output register occupied.
- stats_clr  input  1  clear counters (optional feature).
- grant_cnt  output  N_SRC*CNT_W  per-source popped-word count (optional feature).

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_data=0, out_src=0.
  - State=IDLE, rr_ptr=0, lock_src=0, grant_cnt=0.
  - src_ren is combinationally 0 while rst=1.
- can_pop = !out_valid || out_ready.
  - At most one src_ren is high per cycle, and only when can_pop=1.
  - src_ren is never asserted to an empty source, so the FIFO underflow flag never fires.
- State IDLE:
  - Eligible sources: !src_empty[i] && !src_mask[i] && enable.
  - Pick the first eligible index searching rr_ptr, rr_ptr+1, ... wrapping modulo N_SRC.
  - If one is found and can_pop=1, pop it (sel).
  - If the popped word has EOP=0: go to LOCKED with lock_src=sel.
  - If the popped word has EOP=1: stay IDLE, rr_ptr=(sel+1) mod N_SRC.
- State LOCKED:
  - Only lock_src is considered. src_mask and enable are ignored, so an in-flight packet always completes.
  - Pop when !src_empty[lock_src] && can_pop. If lock_src is empty, no pop occurs (bubble) and no other source is served.
  - Popping a word with EOP=1 returns to IDLE with rr_ptr=(lock_src+1) mod N_SRC.
- Output register:
  - On a pop: out_data <= src_rdata[sel], out_src <= sel, out_valid <= 1 on the next edge. Pop-to-out_valid latency is 1 cycle.
  - With out_ready held at 1, throughput is 1 word/cycle.
  - If out_valid && out_ready and no pop: out_valid <= 0.
  - If out_valid && !out_ready: out_data and out_src hold stable; no pop.
- busy = (state==LOCKED) || out_valid.
- Boundary conditions:
  - N_SRC wrap: rr_ptr=N_SRC-1 followed by a grant gives rr_ptr=0.
  - Single-word packet (EOP on the first word) never enters LOCKED.
  - Source masked while locked: the packet still completes, then that source is skipped.
  - rst mid-packet: state returns to IDLE and the output is dropped. Remaining FIFO contents are the owner's responsibility to clear via the FIFO clear input.

Optional Feature:
- Macro NX_FIFO_RD_ARB_STATS_EN.
- Defined:
  - grant_cnt[i] increments by 1 on each src_ren[i] and saturates at all-ones.
  - stats_clr=1 zeroes all counters on the next edge. Clear wins over a same-cycle increment.
- Undefined:
  - grant_cnt is tied to 0, stats_clr is ignored, and no counter flops exist.

Test Plan:
- Reset, then src_empty=4'b1111 with enable=1 -> src_ren=0, out_valid=0, busy=0 for 10 cycles.
- Sources 0..3 each hold one single-word packet (EOP=1), data=0xA0+i, out_ready=1 -> src_ren one-hot 0,1,2,3 on consecutive cycles; out_data 0xA0..0xA3 with out_src 0..3, first out_valid one cycle after the first pop.
- Src 1 holds a 3-word packet (EOP on word 3) and src 2 holds one word; src 1's FIFO goes empty for 2 cycles after word 1 -> no src 2 pop until src 1's word 3 is popped; output order s1w1, s1w2, s1w3, s2w1.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> src_ren=0 and out_data/out_src stable; out_ready=1 -> one word/cycle resumes with no loss or duplication.
- Set src_mask[0]=1 mid-packet on src 0 and clear enable after packet start -> src 0's packet completes; afterwards only unmasked sources are granted, and none while enable=0.
- With NX_FIFO_RD_ARB_STATS_EN defined and CNT_W=4: 17 pops from src 3 -> grant_cnt[3]=15 (saturated); stats_clr in the same cycle as a pop -> 0.
